pim_input_buffer: RTL and testbench

//  Write-side counterpart of the PIM output buffer: assembles two 1024-bit PIM input vectors from
//  32-bit core-side word writes, then presents both to the PIM macros under a valid/ack handshake.

---
 rtl/pim_input_buffer.sv | 131 +++++++++++++
 tb/tb_pim_input_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pim_input_buffer.sv
// Assembles two VEC_W-bit PIM input vectors from DATA_W-bit core writes and presents
// both to the PIM macros under a valid/ack handshake.
module pim_input_buffer #(
  parameter int DATA_W = 32,
  parameter int VEC_W  = 1024,
  localparam int WORDS = VEC_W / DATA_W,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic              wr_sel_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clear_i,
  input  logic              launch_i,
  input  logic              pim_ack_i,
  output logic              pim_valid_o,
  output logic [VEC_W-1:0]  pim_input_1_o,
  output logic [VEC_W-1:0]  pim_input_2_o,
  output logic [1:0]        bank_full_o,
  output logic              busy_o,
  output logic              err_o
);

  // Handshake: pim_valid_o rises on the launch edge and the vectors stay stable until
  // pim_ack_i is sampled high; the transfer completes on that edge and valid drops with it.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   bank1_q, bank1_d, bank2_q, bank2_d;
  logic [WORDS-1:0]   mask1_q, mask1_d, mask2_q, mask2_d;
  logic [VEC_W-1:0]   out1_q, out1_d, out2_q, out2_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [1:0]         full_q, full_d;
  logic               idx_ok;

  // Only reachable when WORDS is not a power of two.
  assign idx_ok = ({1'b0, wr_idx_i} <= (IDX_W+1)'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    bank1_d = bank1_q;
    bank2_d = bank2_q;
    mask1_d = mask1_q;
    mask2_d = mask2_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          bank1_d = '0;
          bank2_d = '0;
          mask1_d = '0;
          mask2_d = '0;
        end else if (wr_en_i && idx_ok) begin
          if (wr_sel_i) begin
            bank2_d[wr_idx_i*DATA_W +: DATA_W] = wr_data_i;
            mask2_d[wr_idx_i] = 1'b1;
          end else begin
            bank1_d[wr_idx_i*DATA_W +: DATA_W] = wr_data_i;
            mask1_d[wr_idx_i] = 1'b1;
          end
        end
        // Launch snapshots the banks after this cycle's clear/write.
        if (launch_i) begin
          state_d = SEND;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          out1_d  = bank1_d;
          out2_d  = bank2_d;
        end
      end
      SEND: begin
        if (wr_en_i || clear_i || launch_i) err_d = 1'b1;
        if (pim_ack_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          out1_d  = '0;
          out2_d  = '0;
          mask1_d = '0;
          mask2_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    full_d = {&mask2_d, &mask1_d};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bank1_q <= '0;
      bank2_q <= '0;
      mask1_q <= '0;
      mask2_q <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      bank1_q <= bank1_d;
      bank2_q <= bank2_d;
      mask1_q <= mask1_d;
      mask2_q <= mask2_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      full_q  <= full_d;
    end
  end

  assign pim_valid_o   = valid_q;
  assign pim_input_1_o = out1_q;
  assign pim_input_2_o = out2_q;
  assign bank_full_o   = full_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_pim_input_buffer.sv
// Directed plus randomized bench for pim_input_buffer against a word-array reference model.
module tb_pim_input_buffer;
  localparam int DATA_W = 32;
  localparam int VEC_W  = 1024;
  localparam int WORDS  = 32;
  localparam int IDX_W  = 5;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              wr_en_i, wr_sel_i, clear_i, launch_i, pim_ack_i;
  logic [IDX_W-1:0]  wr_idx_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              pim_valid_o, busy_o, err_o;
  logic [VEC_W-1:0]  pim_input_1_o, pim_input_2_o;
  logic [1:0]        bank_full_o;

  always #5 clk = ~clk;

  pim_input_buffer dut (
    .clk_i(clk), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i), .clear_i(clear_i),
    .launch_i(launch_i), .pim_ack_i(pim_ack_i), .pim_valid_o(pim_valid_o),
    .pim_input_1_o(pim_input_1_o), .pim_input_2_o(pim_input_2_o),
    .bank_full_o(bank_full_o), .busy_o(busy_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: banks as word arrays, transfers as a queue of launched snapshots.
  logic [DATA_W-1:0]  m_bank[2][WORDS];
  bit                 m_mask[2][WORDS];
  bit                 m_sending, m_err;
  logic [2*VEC_W-1:0] exp_q[$];

  function automatic logic [2*VEC_W-1:0] snapshot();
    logic [2*VEC_W-1:0] v;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < WORDS; k++)
        v[b*VEC_W + k*DATA_W +: DATA_W] = m_bank[b][k];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < WORDS; k++) begin
        m_bank[b][k] = '0;
        m_mask[b][k] = 1'b0;
      end
    m_sending = 1'b0;
    m_err     = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    if (!rst_ni) begin
      model_reset();
    end else if (!m_sending) begin
      if (clear_i) begin
        for (int b = 0; b < 2; b++)
          for (int k = 0; k < WORDS; k++) begin
            m_bank[b][k] = '0;
            m_mask[b][k] = 1'b0;
          end
      end else if (wr_en_i) begin
        m_bank[wr_sel_i][wr_idx_i] = wr_data_i;
        m_mask[wr_sel_i][wr_idx_i] = 1'b1;
      end
      if (launch_i) begin
        m_sending = 1'b1;
        exp_q.push_back(snapshot());
      end
    end else begin
      if (wr_en_i || clear_i || launch_i) m_err = 1'b1;
      if (pim_ack_i) begin
        m_sending = 1'b0;
        void'(exp_q.pop_front());
        for (int b = 0; b < 2; b++)
          for (int k = 0; k < WORDS; k++) m_mask[b][k] = 1'b0;
      end
    end
  endtask

  task automatic chk(string tag, logic [DATA_W-1:0] obs, logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(string tag, logic [VEC_W-1:0] obs, logic [VEC_W-1:0] exp);
    int d;
    checks++;
    assert (obs === exp) else begin
      errors++;
      d = 0;
      for (int k = WORDS - 1; k >= 0; k--)
        if (obs[k*DATA_W +: DATA_W] !== exp[k*DATA_W +: DATA_W]) d = k;
      $error("FAIL %s: word %0d got %h expected %h", tag, d,
             obs[d*DATA_W +: DATA_W], exp[d*DATA_W +: DATA_W]);
    end
  endtask

  task automatic check_all();
    logic [2*VEC_W-1:0] e;
    logic [1:0] full;
    e = (m_sending && exp_q.size() > 0) ? exp_q[0] : '0;
    full = 2'b11;
    for (int k = 0; k < WORDS; k++) begin
      if (!m_mask[0][k]) full[0] = 1'b0;
      if (!m_mask[1][k]) full[1] = 1'b0;
    end
    chk("valid", 32'(pim_valid_o), 32'(m_sending));
    chk("busy", 32'(busy_o), 32'(m_sending));
    chk("err", 32'(err_o), 32'(m_err));
    chk("bank_full", 32'(bank_full_o), 32'(full));
    chk_vec("input_1", pim_input_1_o, e[VEC_W-1:0]);
    chk_vec("input_2", pim_input_2_o, e[2*VEC_W-1:VEC_W]);
  endtask

  // Driver: apply one cycle of inputs, advance the model on the edge, check #1 later.
  task automatic step(input bit rst_n, input bit wr, input bit sel, input int idx,
                      input logic [DATA_W-1:0] data, input bit clr, input bit lau,
                      input bit ack);
    rst_ni    = rst_n;
    wr_en_i   = wr;
    wr_sel_i  = sel;
    wr_idx_i  = IDX_W'(idx);
    wr_data_i = data;
    clear_i   = clr;
    launch_i  = lau;
    pim_ack_i = ack;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input bit ack);
    step(1, 0, 0, 0, '0, 0, 0, ack);
  endtask

  initial begin
    rst_ni = 1'b0; wr_en_i = 1'b0; wr_sel_i = 1'b0; wr_idx_i = '0; wr_data_i = '0;
    clear_i = 1'b0; launch_i = 1'b0; pim_ack_i = 1'b0;
    model_reset();

    // Reset state
    step(0, 0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, 0, '0, 0, 0, 0);
    idle(0);

    // 1: fill bank 1, launch
    for (int k = 0; k < WORDS; k++) step(1, 1, 0, k, DATA_W'(k) * 32'h01010101, 0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 1, 0);
    chk("t1_word5", pim_input_1_o[5*DATA_W +: DATA_W], 32'h05050505);
    chk("t1_word31", pim_input_1_o[31*DATA_W +: DATA_W], 32'h1F1F1F1F);
    chk("t1_full", 32'(bank_full_o), 32'h1);

    // 2: writes while SEND are rejected, then ack
    for (int i = 0; i < 5; i++) step(1, 1, 0, i, 32'hDEADBEEF, 0, 0, 0);
    chk("t2_err", 32'(err_o), 32'h1);
    idle(1);
    chk("t2_valid_after_ack", 32'(pim_valid_o), 32'h0);
    chk("t2_full_after_ack", 32'(bank_full_o), 32'h0);
    step(1, 0, 0, 0, '0, 0, 1, 0);
    chk("t2_intact", pim_input_1_o[2*DATA_W +: DATA_W], 32'h02020202);
    idle(1);

    // 3: same-cycle write and launch
    step(1, 1, 1, 31, 32'hA5A5A5A5, 0, 1, 0);
    chk("t3_top", pim_input_2_o[1023:992], 32'hA5A5A5A5);
    idle(0);
    idle(1);

    // 4: write + clear + launch together launches zeros
    step(1, 1, 0, 3, 32'h12345678, 1, 1, 0);
    chk_vec("t4_zero_1", pim_input_1_o, '0);
    chk("t4_full", 32'(bank_full_o), 32'h0);
    idle(1);

    // 5: reset mid-SEND
    step(1, 1, 1, 7, 32'h0BADF00D, 0, 1, 0);
    step(1, 1, 0, 0, 32'h1, 0, 0, 0);
    step(0, 0, 0, 0, '0, 0, 0, 0);
    chk("t5_err_cleared", 32'(err_o), 32'h0);
    step(1, 0, 0, 0, '0, 0, 1, 0);
    chk_vec("t5_zero_2", pim_input_2_o, '0);
    idle(1);

    // 6: ack held high in IDLE, one-cycle SEND, back-to-back launch
    step(1, 1, 0, 9, 32'hCAFEF00D, 0, 0, 1);
    idle(1);
    step(1, 0, 0, 0, '0, 0, 1, 1);
    chk("t6_valid_up", 32'(pim_valid_o), 32'h1);
    idle(1);
    chk("t6_valid_down", 32'(pim_valid_o), 32'h0);
    step(1, 0, 0, 0, '0, 0, 1, 0);
    chk("t6_relaunch", 32'(pim_valid_o), 32'h1);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, WORDS - 1), $urandom, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
